// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// width codes and the access legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Misaligned address, undefined width code, or unsigned-width store.
    function automatic logic access_err(input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        logic err_s;
        case (f3)
            F3_B:    err_s = 1'b0;
            F3_H:    err_s = off[0];
            F3_HU:   err_s = off[0] | wr;
            F3_W:    err_s = (off != 2'b00);
            F3_BU:   err_s = wr;
            default: err_s = 1'b1;
        endcase
        return err_s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word and
// merges sub-word store data into the previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and load extension.
    always_comb begin
        byte_s = mem_word[{offset, 3'b000} +: 8];
        if (offset[1]) begin
            half_s = mem_word[31:16];
        end else begin
            half_s = mem_word[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = mem_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: only the addressed lane changes.
    always_comb begin
        store_word = mem_word;
        case (funct3)
            F3_B: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            F3_W:    store_word = wdata;
            default: store_word = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, valid/ready on both CPU sides,
// read-modify-write for byte and halfword stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e        state_r;
    logic [1:0]        off_r;
    logic [2:0]        f3_r;
    logic              write_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_write_data_r;
    logic [31:0]       load_data_s;
    logic [31:0]       store_word_s;
    logic              word_store_s;

    lsu_align u_align (
        .mem_word   (mem_read_data),
        .offset     (off_r),
        .funct3     (f3_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    assign word_store_s   = write_r & (f3_r == F3_W);
    assign req_ready      = (state_r == ST_IDLE);
    assign rsp_valid      = (state_r == ST_RESP);
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_err        = rsp_err_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_write_data_r;
    // Gated by rst so a write pending at the reset edge never reaches memory.
    assign mem_write_en   = ~rst & (((state_r == ST_ACCESS) & word_store_s) |
                                    (state_r == ST_WRITE));

    // Control FSM with registered response and memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            off_r            <= 2'b00;
            f3_r             <= 3'b000;
            write_r          <= 1'b0;
            wdata_r          <= 32'h0000_0000;
            rsp_rdata_r      <= 32'h0000_0000;
            rsp_err_r        <= 1'b0;
            mem_addr_r       <= '0;
            mem_write_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        off_r   <= req_addr[1:0];
                        f3_r    <= req_funct3;
                        write_r <= req_write;
                        wdata_r <= req_wdata;
                        if (access_err(req_write, req_funct3, req_addr[1:0])) begin
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                            state_r     <= ST_RESP;
                        end else begin
                            mem_addr_r       <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_write_data_r <= req_write ? req_wdata : 32'h0000_0000;
                            state_r          <= ST_ACCESS;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (write_r && !word_store_s) begin
                        mem_write_data_r <= store_word_s;
                        state_r          <= ST_WRITE;
                    end else begin
                        rsp_rdata_r      <= write_r ? 32'h0000_0000 : load_data_s;
                        rsp_err_r        <= 1'b0;
                        mem_addr_r       <= '0;
                        mem_write_data_r <= 32'h0000_0000;
                        state_r          <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    rsp_rdata_r      <= 32'h0000_0000;
                    rsp_err_r        <= 1'b0;
                    mem_addr_r       <= '0;
                    mem_write_data_r <= 32'h0000_0000;
                    state_r          <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// operations against a byte-level reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] tb_mem  [16];
    logic [31:0] ref_mem [16];

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_rdata;
    int          last_lat;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = tb_mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write_en) tb_mem[mem_addr[5:2]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: sizes in bytes, byte-by-byte memory update.
    task automatic ref_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd,
                          output int lat, output logic [31:0] new_word);
        int size;
        int off;
        logic [31:0] w;
        logic [31:0] v;
        size = 1 << f3[1:0];
        off  = a % 4;
        err  = 1'b0;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b1;
        if (wr && f3[2]) err = 1'b1;
        if ((a % size) != 0) err = 1'b1;
        w = ref_mem[a[5:2]];
        rd = 32'h0;
        new_word = w;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            lat = 2;
            v = w >> (8 * off);
            if (size == 1) rd = f3[2] ? (v & 32'hFF) : 32'($signed(v[7:0]));
            else if (size == 2) rd = f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
            else rd = v;
        end else begin
            lat = (size == 4) ? 2 : 3;
            for (int i = 0; i < size; i++) new_word[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[a[5:2]] = new_word;
        end
    endtask

    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] e_word;
        int          e_lat;
        int          cyc;
        int          wrcnt;
        logic [31:0] held;
        ref_op(wr, f3, a, wd, e_err, e_rd, e_lat, e_word);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        cyc = 0; wrcnt = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (mem_write_en) begin
                wrcnt++;
                chk("wr_addr", mem_addr, {a[31:2], 2'b00});
                chk("wr_data", mem_write_data, e_word);
            end
            if (rsp_valid || cyc > 8) break;
        end
        last_lat = cyc;
        last_rdata = rsp_rdata;
        chk("latency", cyc, e_lat);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("addr_resp", mem_addr, 32'h0);
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, held);
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("back_idle", {31'b0, req_ready}, 32'd1);
        chk("wr_count", wrcnt, (wr && !e_err) ? 32'd1 : 32'd0);
        chk("mem_word", tb_mem[a[5:2]], ref_mem[a[5:2]]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tb_mem[i] = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_write_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        run_op(1'b0, 3'b000, 32'h13, 32'h0, 0); chk("lb_13", last_rdata, 32'hFFFFFF88);
        run_op(1'b0, 3'b100, 32'h13, 32'h0, 0); chk("lbu_13", last_rdata, 32'h00000088);
        run_op(1'b0, 3'b001, 32'h12, 32'h0, 0); chk("lh_12", last_rdata, 32'hFFFF8899);
        run_op(1'b0, 3'b101, 32'h10, 32'h0, 0); chk("lhu_10", last_rdata, 32'h0000AABB);
        run_op(1'b1, 3'b000, 32'h11, 32'hCC, 0); chk("sb_word", tb_mem[4], 32'h8899CCBB);
        chk("sb_lat", last_lat, 32'd3);
        run_op(1'b0, 3'b010, 32'h12, 32'h0, 0); chk("lw_mis_lat", last_lat, 32'd1);
        run_op(1'b1, 3'b010, 32'h14, 32'h12345678, 3); chk("sw_word", tb_mem[5], 32'h12345678);

        // Reset during the WRITE phase of a halfword store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h22; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sh_we_write", {31'b0, mem_write_en}, 32'd1);
        rst = 1'b1;
        #1 chk("sh_we_gated", {31'b0, mem_write_en}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst2_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst2_mem_addr", mem_addr, 32'h0);
        chk("rst2_mem_wdata", mem_write_data, 32'h0);
        chk("rst2_we", {31'b0, mem_write_en}, 32'd0);
        chk("rst2_mem", tb_mem[8], ref_mem[8]);

        for (int n = 0; n < 80; n++) begin
            run_op(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
                   $urandom, $urandom_range(0, 3));
        end
        for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
